// File: rtl/key_detector.sv
`default_nettype none
// ============================================================================
// Module   : key_detector
// Brief    : Counts dark RGB565 pixels per key zone inside a horizontal band
//            and publishes a hysteresis-filtered key vector once per frame,
//            plus one-cycle note-on/note-off events.
//            Optional macro KEY_DETECT_DEBOUNCE_EN: two-frame agreement.
// Revision : 1.0
// ============================================================================
module key_detector #(
    parameter int KEYS      = 8,
    parameter int H_RES     = 320,
    parameter int V_RES     = 240,
    parameter int KEY_W     = 40,
    parameter int ROW_TOP   = 160,
    parameter int ROW_BOT   = 191,
    parameter int THRESH    = 64,
    parameter int COUNT_ON  = 200,
    parameter int COUNT_OFF = 100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_start,
    input  logic            pix_valid,
    input  logic [15:0]     pix_data,
    output logic [KEYS-1:0] keys,
    output logic            keys_valid,
    output logic [KEYS-1:0] note_on,
    output logic [KEYS-1:0] note_off,
    output logic [15:0]     debug_out
);
    localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W = $clog2(V_RES + 1);
    localparam int Z_W = (KEYS > 1) ? $clog2(KEYS) : 1;
    localparam int I_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam int C_W = 11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_EVAL    = 2'd2;
    localparam logic [1:0] ST_PUBLISH = 2'd3;

    localparam logic [X_W-1:0] c_X_LAST  = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] c_Y_LAST  = Y_W'(V_RES - 1);
    localparam logic [Y_W-1:0] c_ROW_TOP = Y_W'(ROW_TOP);
    localparam logic [Y_W-1:0] c_ROW_BOT = Y_W'(ROW_BOT);
    localparam logic [I_W-1:0] c_I_LAST  = I_W'(KEY_W - 1);
    localparam logic [Z_W-1:0] c_K_LAST  = Z_W'(KEYS - 1);
    localparam logic [7:0]     c_THRESH  = 8'(THRESH);
    localparam logic [C_W-1:0] c_ON      = C_W'(COUNT_ON);
    localparam logic [C_W-1:0] c_OFF     = C_W'(COUNT_OFF);

    logic [1:0]     state_q, state_d;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic [Z_W-1:0] zone_q;
    logic [I_W-1:0] intra_q;
    logic [C_W-1:0] cnt_q [KEYS];
    logic [Z_W-1:0] idx_q;
    logic [KEYS-1:0] shadow_q, keys_q, on_q, off_q;
    logic           valid_q, pend_q;
    logic [7:0]     frame_cnt_q;

    logic [7:0]      w_luma;
    logic            w_dark, w_in_band, w_accept, w_clear, w_last_pix;
    logic [C_W-1:0]  w_cnt_sel;
    logic            w_new;
    logic [KEYS-1:0] w_result, w_old_vec, w_keys_nxt;
    logic [7:0]      w_keys8;

    assign w_luma     = {2'b0, pix_data[15:11], 1'b0} + {2'b0, pix_data[10:5]}
                      + {3'b0, pix_data[4:0]};
    assign w_dark     = (w_luma < c_THRESH);
    assign w_in_band  = (y_q >= c_ROW_TOP) && (y_q <= c_ROW_BOT);
    assign w_last_pix = (x_q == c_X_LAST) && (y_q == c_Y_LAST);
    // frame_start outranks a pixel in the same cycle
    assign w_accept   = (state_q == ST_ACCUM) && pix_valid && !frame_start;
    assign w_clear    = (frame_start && ((state_q == ST_IDLE) || (state_q == ST_ACCUM)))
                     || ((state_q == ST_PUBLISH) && (pend_q || frame_start));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (frame_start) state_d = ST_ACCUM;
            ST_ACCUM:   if (w_accept && w_last_pix) state_d = ST_EVAL;
            ST_EVAL:    if (idx_q == c_K_LAST) state_d = ST_PUBLISH;
            ST_PUBLISH: state_d = (pend_q || frame_start) ? ST_ACCUM : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

`ifdef KEY_DETECT_DEBOUNCE_EN
    logic [KEYS-1:0] prev_q;
    assign w_old_vec  = prev_q;
    // a key only moves when this frame's result matches the previous one
    assign w_keys_nxt = (~(w_result ^ prev_q) & w_result) | ((w_result ^ prev_q) & keys_q);
`else
    assign w_old_vec  = shadow_q;
    assign w_keys_nxt = w_result;
`endif

    always_comb begin
        w_cnt_sel = cnt_q[idx_q];
        if (w_cnt_sel >= c_ON)      w_new = 1'b1;
        else if (w_cnt_sel < c_OFF) w_new = 1'b0;
        else                        w_new = w_old_vec[idx_q];
        w_result        = shadow_q;
        w_result[idx_q] = w_new;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q     <= '0;
            y_q     <= '0;
            zone_q  <= '0;
            intra_q <= '0;
            for (int k = 0; k < KEYS; k++) cnt_q[k] <= '0;
        end else if (w_clear) begin
            x_q     <= '0;
            y_q     <= '0;
            zone_q  <= '0;
            intra_q <= '0;
            for (int k = 0; k < KEYS; k++) cnt_q[k] <= '0;
        end else if (w_accept) begin
            if (x_q == c_X_LAST) begin
                x_q     <= '0;
                y_q     <= y_q + Y_W'(1);
                zone_q  <= '0;
                intra_q <= '0;
            end else begin
                x_q <= x_q + X_W'(1);
                if (intra_q == c_I_LAST) begin
                    intra_q <= '0;
                    zone_q  <= zone_q + Z_W'(1);
                end else begin
                    intra_q <= intra_q + I_W'(1);
                end
            end
            if (w_dark && w_in_band && (cnt_q[zone_q] != '1))
                cnt_q[zone_q] <= cnt_q[zone_q] + C_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            keys_q      <= '0;
            on_q        <= '0;
            off_q       <= '0;
            valid_q     <= 1'b0;
            pend_q      <= 1'b0;
            frame_cnt_q <= '0;
`ifdef KEY_DETECT_DEBOUNCE_EN
            prev_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= 1'b0;
            on_q    <= '0;
            off_q   <= '0;
            if ((state_q == ST_EVAL) && frame_start) pend_q <= 1'b1;
            else if (state_q == ST_PUBLISH)          pend_q <= 1'b0;
            if (state_q == ST_EVAL) begin
                shadow_q <= w_result;
                idx_q    <= idx_q + Z_W'(1);
                // outputs are loaded on the final EVAL edge so they show during PUBLISH
                if (idx_q == c_K_LAST) begin
                    idx_q       <= '0;
                    keys_q      <= w_keys_nxt;
                    valid_q     <= 1'b1;
                    on_q        <= w_keys_nxt & ~keys_q;
                    off_q       <= ~w_keys_nxt & keys_q;
                    frame_cnt_q <= frame_cnt_q + 8'd1;
`ifdef KEY_DETECT_DEBOUNCE_EN
                    prev_q      <= w_result;
`endif
                end
            end
        end
    end

    generate
        if (KEYS >= 8) begin : g_dbg_wide
            assign w_keys8 = keys_q[7:0];
        end else begin : g_dbg_narrow
            assign w_keys8 = {{(8 - KEYS){1'b0}}, keys_q};
        end
    endgenerate

    assign keys       = keys_q;
    assign keys_valid = valid_q;
    assign note_on    = on_q;
    assign note_off   = off_q;
    assign debug_out  = {frame_cnt_q, w_keys8};

endmodule
`default_nettype wire

// File: tb/tb_key_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_detector
// Brief    : Self-checking bench for key_detector on a reduced 32x8 frame.
// Revision : 1.0
// ============================================================================
module tb_key_detector;
    localparam int H = 32, V = 8, KW = 4, RT = 2, RB = 5, NPIX = H * V;

    logic        clk = 1'b0, rst = 1'b0, frame_start = 1'b0, pix_valid = 1'b0;
    logic [15:0] pix_data = 16'h0;
    logic [7:0]  keys, note_on, note_off;
    logic        keys_valid;
    logic [15:0] debug_out;

    key_detector #(
        .KEYS(8), .H_RES(H), .V_RES(V), .KEY_W(KW), .ROW_TOP(RT), .ROW_BOT(RB),
        .THRESH(64), .COUNT_ON(10), .COUNT_OFF(5)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_data(pix_data), .keys(keys), .keys_valid(keys_valid),
        .note_on(note_on), .note_off(note_off), .debug_out(debug_out)
    );

    always #5 clk = ~clk;

    // dark[z] = dark pixels in zone z's band area; ob = black outside band;
    // bnd = use luma-63 dark / luma-64 light pixels instead of black/white
    typedef struct packed {
        logic [7:0][4:0] dark;
        logic            ob;
        logic            bnd;
        logic [7:0]      k;
        logic [7:0]      on;
        logic [7:0]      off;
    } frame_t;

    frame_t     tbl [12];
    int         checks = 0, errors = 0;
    int         n_valid = 0, n_note = 0, exp_pulses = 0, exp_notes = 0;
    logic [7:0] exp_fcnt = 8'd0;

    always @(posedge clk) begin
        if (keys_valid) n_valid++;
        if ((note_on != 8'h0) || (note_off != 8'h0)) n_note++;
    end

    function automatic frame_t mkf(input int z, input int n, input logic ob, input logic bnd,
                                   input logic [7:0] k, input logic [7:0] on, input logic [7:0] off);
        frame_t f;
        f = '0;
        if (z >= 0) f.dark[z] = n[4:0];
        f.ob = ob; f.bnd = bnd; f.k = k; f.on = on; f.off = off;
        return f;
    endfunction

    function automatic logic [15:0] pix_of(input frame_t f, input int idx);
        int x, y;
        logic dk;
        x = idx % H;
        y = idx / H;
        if (y >= RT && y <= RB) dk = (((y - RT) * KW + (x % KW)) < int'(f.dark[x / KW]));
        else                    dk = f.ob;
        if (f.bnd) return dk ? 16'h07E0 : 16'h07E1;
        return dk ? 16'h0000 : 16'hFFFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        frame_start = 1'b1;
        pix_valid   = 1'b0;
    endtask

    task automatic send_pixels(input frame_t f, input int first, input int n);
        for (int p = first; p < first + n; p++) begin
            @(negedge clk);
            frame_start = 1'b0;
            pix_valid   = 1'b1;
            pix_data    = pix_of(f, p);
        end
    endtask

    // Waits for the publish after the last pixel; optional frame_start at
    // cycle fs_at and dark pixel noise while EVAL runs.
    task automatic wait_publish(input string name, input logic [7:0] ek, input logic [7:0] eon,
                                input logic [7:0] eoff, input int fs_at, input bit noise);
        int lat;
        lat = 0;
        chk({name, " pulse total"}, n_valid, exp_pulses);
        chk({name, " note total"}, n_note, exp_notes);
        for (int j = 1; j <= 20 && lat == 0; j++) begin
            @(negedge clk);
            if (keys_valid) lat = j;
            else begin
                frame_start = (j == fs_at);
                pix_valid   = noise;
                pix_data    = 16'h0000;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no keys_valid within 20 cycles, expected at 9", name);
        end else begin
            exp_pulses++;
            if ((eon | eoff) != 8'h0) exp_notes++;
            exp_fcnt = exp_fcnt + 8'd1;
            chk({name, " latency"}, lat, 9);
            chk({name, " keys"}, keys, ek);
            chk({name, " note_on"}, note_on, eon);
            chk({name, " note_off"}, note_off, eoff);
            chk({name, " debug_out"}, debug_out, {exp_fcnt, ek});
        end
    endtask

    initial begin
        frame_t wf, fa, fb;
        logic [7:0] ak, aon, aoff, bk, bon, boff;

`ifdef KEY_DETECT_DEBOUNCE_EN
        tbl[0]  = mkf(-1, 0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        tbl[1]  = mkf(2, 16, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        tbl[2]  = mkf(-1, 0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        tbl[3]  = mkf(2, 16, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        tbl[4]  = mkf(2, 16, 1'b0, 1'b0, 8'h04, 8'h04, 8'h00);
        tbl[5]  = mkf(-1, 0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h00);
        tbl[6]  = mkf(-1, 0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h04);
        for (int i = 7; i < 12; i++) tbl[i] = mkf(-1, 0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        ak = 8'h00; aon = 8'h00; aoff = 8'h00;
        bk = 8'h00; bon = 8'h00; boff = 8'h00;
`else
        tbl[0]  = mkf(-1, 0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        tbl[1]  = mkf(2, 16, 1'b1, 1'b0, 8'h04, 8'h04, 8'h00);
        tbl[2]  = mkf(-1, 0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h04);
        tbl[3]  = mkf(0, 16, 1'b0, 1'b0, 8'h01, 8'h01, 8'h00);
        tbl[4]  = mkf(0, 7,  1'b0, 1'b0, 8'h01, 8'h00, 8'h00);
        tbl[5]  = mkf(0, 4,  1'b0, 1'b0, 8'h00, 8'h00, 8'h01);
        tbl[6]  = mkf(0, 9,  1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        tbl[7]  = mkf(0, 10, 1'b0, 1'b1, 8'h01, 8'h01, 8'h00);
        tbl[8]  = mkf(0, 5,  1'b0, 1'b1, 8'h01, 8'h00, 8'h00);
        tbl[9]  = mkf(7, 16, 1'b0, 1'b0, 8'h80, 8'h80, 8'h01);
        tbl[10] = mkf(-1, 0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h80);
        tbl[11] = mkf(-1, 0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        ak = 8'h08; aon = 8'h08; aoff = 8'h00;
        bk = 8'h00; bon = 8'h00; boff = 8'h08;
`endif
        wf = mkf(-1, 0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk("reset keys", keys, 8'h00);
        chk("reset keys_valid", keys_valid, 1'b0);
        chk("reset note_on", note_on, 8'h00);
        chk("reset note_off", note_off, 8'h00);
        chk("reset debug_out", debug_out, 16'h0000);

        for (int i = 0; i < 12; i++) begin
            start_frame();
            send_pixels(tbl[i], 0, NPIX);
            wait_publish($sformatf("frame%0d", i), tbl[i].k, tbl[i].on, tbl[i].off, 0, 1'b0);
        end

        // abort at y=4: first frame's band rows must not leak into the restarted frame
        fa = mkf(0, 16, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        fb = mkf(0, 4,  1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        start_frame();
        send_pixels(fa, 0, 4 * H);
        @(negedge clk);
        frame_start = 1'b1;
        pix_valid   = 1'b1;
        pix_data    = 16'h0000;
        send_pixels(fb, 0, NPIX);
        wait_publish("abort", 8'h00, 8'h00, 8'h00, 0, 1'b0);

        // frame_start during EVAL, noise pixels during EVAL, next frame right after PUBLISH
        fa = mkf(3, 16, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        fb = mkf(3, 0,  1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        start_frame();
        send_pixels(fa, 0, NPIX);
        wait_publish("eval-fs A", ak, aon, aoff, 3, 1'b1);
        send_pixels(fb, 0, NPIX);
        wait_publish("eval-fs B", bk, bon, boff, 0, 1'b0);

        // reset mid-frame: nothing published, frame counter cleared
        start_frame();
        send_pixels(fa, 0, 100);
        @(negedge clk);
        rst       = 1'b0;
        pix_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst keys", keys, 8'h00);
        chk("midrst debug_out", debug_out, 16'h0000);
        send_pixels(fa, 100, NPIX - 100);
        @(negedge clk);
        pix_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst pulse total", n_valid, exp_pulses);
        exp_fcnt = 8'd0;

        start_frame();
        send_pixels(wf, 0, NPIX);
        wait_publish("post-reset", 8'h00, 8'h00, 8'h00, 0, 1'b0);

        repeat (4) @(negedge clk);
        chk("final pulse total", n_valid, exp_pulses);
        chk("final note total", n_note, exp_notes);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
